// File: rtl/i2s_buf_sched_pkg.sv
// Shared types and constants for the I2S double-buffer DMA sequencer.
// Status bit positions are shared with the APB register block.
package i2s_buf_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_ARM    = 3'd2,
      ST_REQ    = 3'd3,
      ST_WAIT   = 3'd4,
      ST_RETIRE = 3'd5
   } state_e;

   localparam int BEAT_BYTES = 8;

   localparam int STAT_A_VALID  = 0;
   localparam int STAT_B_VALID  = 1;
   localparam int STAT_CUR_BUF  = 2;
   localparam int STAT_BUSY     = 3;
   localparam int STAT_UNDERRUN = 4;
   localparam int STAT_W        = 5;

   function automatic int burst_bytes(input int beats);
      return beats * BEAT_BYTES;
   endfunction

endpackage

// File: rtl/i2s_buf_sched_if.sv
// Read-request channel between the buffer sequencer (master) and the MIC read engine (slave).
interface i2s_buf_sched_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [7:0]        req_beats;
   logic              rd_done;

   modport master (
      output req_valid,
      output req_addr,
      output req_beats,
      input  req_ready,
      input  rd_done
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      input  req_beats,
      output req_ready,
      output rd_done
   );
endinterface

// File: rtl/i2s_buf_sched.sv
// Double-buffer (A/B) DMA sequencer: walks the current buffer in fixed bursts,
// one request outstanding, then retires it, swaps buffers and pulses irq_edge.
module i2s_buf_sched
   import i2s_buf_sched_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int BUF_BYTES   = 4096,
   parameter int BURST_BEATS = 8,
   parameter int FREE_W      = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [ADDR_W-1:0]  buf_a_addr,
   input  logic [ADDR_W-1:0]  buf_b_addr,
   input  logic               set_a_valid,
   input  logic               set_b_valid,
   input  logic               clr_underrun,
   input  logic [FREE_W-1:0]  fifo_free,
   i2s_buf_sched_if.master    bus,
   output logic               a_valid,
   output logic               b_valid,
   output logic               cur_buf,
   output logic               busy,
   output logic               underrun,
   output logic               irq_edge
);

   localparam int                BURST_BYTES = burst_bytes(BURST_BEATS);
   localparam int                OFF_W       = $clog2(BUF_BYTES) + 1;
   localparam logic [OFF_W-1:0]  OFF_STEP    = OFF_W'(BURST_BYTES);
   localparam logic [OFF_W-1:0]  OFF_END     = OFF_W'(BUF_BYTES);
   localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~ADDR_W'(BURST_BYTES - 1);
   localparam logic [FREE_W-1:0] FREE_MIN    = FREE_W'(BURST_BEATS);

   state_e             r_state;
   logic [OFF_W-1:0]   r_offset;
   logic               r_cur_buf;
   logic               r_busy;
   logic               r_req_valid;
   logic [ADDR_W-1:0]  r_req_addr;
   logic               r_irq;
   logic               r_a_valid;
   logic               r_b_valid;
   logic               r_underrun;

   logic               w_cur_valid;
   logic [ADDR_W-1:0]  w_cur_base;
   logic [OFF_W-1:0]   w_off_next;
   logic               w_retire;
   logic               w_underrun_set;

   assign w_cur_valid    = r_cur_buf ? r_b_valid : r_a_valid;
   assign w_cur_base     = (r_cur_buf ? buf_b_addr : buf_a_addr) & ALIGN_MASK;
   assign w_off_next     = r_offset + OFF_STEP;
   assign w_retire       = (r_state == ST_RETIRE);
   assign w_underrun_set = (r_state == ST_SELECT) && enable && !w_cur_valid;

   // Buffer valid flags and sticky underrun; a set pulse beats a same-cycle clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a_valid  <= 1'b0;
         r_b_valid  <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         if (set_a_valid) begin
            r_a_valid <= 1'b1;
         end else if (w_retire && !r_cur_buf) begin
            r_a_valid <= 1'b0;
         end else begin
            r_a_valid <= r_a_valid;
         end

         if (set_b_valid) begin
            r_b_valid <= 1'b1;
         end else if (w_retire && r_cur_buf) begin
            r_b_valid <= 1'b0;
         end else begin
            r_b_valid <= r_b_valid;
         end

         if (w_underrun_set) begin
            r_underrun <= 1'b1;
         end else if (clr_underrun) begin
            r_underrun <= 1'b0;
         end else begin
            r_underrun <= r_underrun;
         end
      end
   end

   // Sequencer FSM with registered request, busy and irq outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_offset    <= '0;
         r_cur_buf   <= 1'b0;
         r_busy      <= 1'b0;
         r_req_valid <= 1'b0;
         r_req_addr  <= '0;
         r_irq       <= 1'b0;
      end else begin
         r_irq <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_offset <= '0;
               if (enable) begin
                  r_state <= ST_SELECT;
                  r_busy  <= 1'b1;
               end else begin
                  r_busy  <= 1'b0;
               end
            end
            ST_SELECT: begin
               if (!enable) begin
                  r_state  <= ST_IDLE;
                  r_busy   <= 1'b0;
                  r_offset <= '0;
               end else if (w_cur_valid) begin
                  r_state <= ST_ARM;
               end else begin
                  r_state <= ST_SELECT;
               end
            end
            ST_ARM: begin
               if (!enable) begin
                  r_state  <= ST_IDLE;
                  r_busy   <= 1'b0;
                  r_offset <= '0;
               end else if (fifo_free >= FREE_MIN) begin
                  r_state     <= ST_REQ;
                  r_req_valid <= 1'b1;
                  r_req_addr  <= w_cur_base + ADDR_W'(r_offset);
               end else begin
                  r_state <= ST_ARM;
               end
            end
            ST_REQ: begin
               // The request is never withdrawn, even if enable drops meanwhile.
               if (bus.req_ready) begin
                  r_state     <= ST_WAIT;
                  r_req_valid <= 1'b0;
               end else begin
                  r_state <= ST_REQ;
               end
            end
            ST_WAIT: begin
               if (bus.rd_done) begin
                  if (w_off_next == OFF_END) begin
                     r_state  <= ST_RETIRE;
                     r_offset <= w_off_next;
                  end else if (enable) begin
                     r_state  <= ST_ARM;
                     r_offset <= w_off_next;
                  end else begin
                     r_state  <= ST_IDLE;
                     r_busy   <= 1'b0;
                     r_offset <= '0;
                  end
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            ST_RETIRE: begin
               r_cur_buf <= ~r_cur_buf;
               r_offset  <= '0;
               r_irq     <= 1'b1;
               if (enable) begin
                  r_state <= ST_SELECT;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_busy      <= 1'b0;
               r_req_valid <= 1'b0;
               r_offset    <= '0;
            end
         endcase
      end
   end

   assign bus.req_valid = r_req_valid;
   assign bus.req_addr  = r_req_addr;
   assign bus.req_beats = 8'(BURST_BEATS);

   assign a_valid  = r_a_valid;
   assign b_valid  = r_b_valid;
   assign cur_buf  = r_cur_buf;
   assign busy     = r_busy;
   assign underrun = r_underrun;
   assign irq_edge = r_irq;

endmodule
